// File: rtl/uart_tx_sched_if.sv
// Requester and uart_tx side of the transmit scheduler, bundled as one interface.
// The master modport is the scheduler. The slave modport is the environment:
// the requesters together with the uart_tx done flag.
interface uart_tx_sched_if #(
  parameter int N_REQ = 4,
  parameter int D_W   = 8
);
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*D_W-1:0] req_data;
  logic [N_REQ-1:0]     req_last;
  logic [N_REQ-1:0]     req_ready;
  logic [D_W-1:0]       tx_byte;
  logic                 tx_start;
  logic                 tx_done;

  modport master (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_byte, tx_start
  );

  modport slave (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_byte, tx_start
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between N_REQ byte requesters.
// A grant is held across a multi-byte frame until the requester flags its last byte.
// A watchdog aborts a transmission whose done edge never arrives.
module uart_tx_sched #(
  parameter  int N_REQ       = 4,
  parameter  int D_W         = 8,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int IDW         = $clog2(N_REQ),
  localparam int WDW         = $clog2(TIMEOUT_CYC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_sched_if.master       bus,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_LOCK} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic             lock_q, lock_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [D_W-1:0]   byte_q, byte_d;
  logic             tx_done_q;

  logic [D_W-1:0]   req_bytes [N_REQ];
  logic             pick_vld;
  logic [IDW-1:0]   pick_id;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   next_rr;
  logic             done_edge;
  logic             wd_expired;
  logic [N_REQ-1:0] ready;

  // Slice the flat data bus into one byte per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = bus.req_data[g*D_W +: D_W];
  end

  // Only a rising edge of the level done flag completes a byte. A done flag
  // that is already high when WAIT is entered does not count as completion.
  assign done_edge  = bus.tx_done && !tx_done_q;
  assign wd_expired = (wd_q == WDW'(TIMEOUT_CYC - 1));
  assign next_rr    = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Pick the first valid requester at or after the rr pointer, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_q;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(rr_q) + k) % N_REQ);
      if (!pick_vld && bus.req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // State register plus the datapath registers that travel with it.
  // tx_done is sampled every cycle so that edge detection is valid on WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      lock_q    <= 1'b0;
      wd_q      <= '0;
      byte_q    <= '0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      lock_q    <= lock_d;
      wd_q      <= wd_d;
      byte_q    <= byte_d;
      tx_done_q <= bus.tx_done;
    end
  end

  // Next-state logic. It covers arbitration, frame locking and the watchdog.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    wd_d    = wd_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          byte_d  = req_bytes[pick_id];
          grant_d = pick_id;
          lock_d  = ~bus.req_last[pick_id];
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (done_edge) begin
          if (lock_q) begin
            state_d = S_LOCK;
          end else begin
            rr_d    = next_rr;
            state_d = S_IDLE;
          end
        end else if (wd_expired) begin
          lock_d  = 1'b0;
          rr_d    = next_rr;
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (bus.req_valid[grant_q]) begin
          byte_d  = req_bytes[grant_q];
          lock_d  = ~bus.req_last[grant_q];
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. The ready strobe is combinational so a byte is taken in the cycle it is offered.
  always_comb begin
    ready       = '0;
    bus.tx_start = 1'b0;
    timeout_err = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (pick_vld) ready[pick_id] = 1'b1;
      S_START: bus.tx_start = 1'b1;
      S_WAIT:  timeout_err = wd_expired && !done_edge;
      S_LOCK:  ready[grant_q] = bus.req_valid[grant_q];
      default: ready = '0;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.tx_byte   = byte_q;
  assign grant_id      = grant_q;

endmodule
